// File: rtl/i2s_dac_tx.sv
// I2S playback transmitter: buffers N-bit samples in a small FIFO and sends each one
// on both channels of an I2S frame, with the codec acting as BCLK/LRCK master.
module i2s_dac_tx #(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             sample_data,
    input  logic                     valid,
    output logic                     ready,
    input  logic                     bclk,
    input  logic                     daclrc,
    output logic                     dacdat,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(N + 1);

    // state | meaning
    // IDLE  | not frame-aligned, line held low until the next lr_fall
    // LEFT  | shifting the current sample on the left channel
    // RIGHT | repeating the same sample on the right channel
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    logic [2:0]    bclk_sync_q;
    logic [2:0]    lr_sync_q;
    logic          bclk_fall;
    logic          lr_fall;
    logic          lr_rise;

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   fill_q;
    logic [AW:0]   fill_d;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          frame_start;
    logic          glitch;

    state_t        state_q;
    logic [N-1:0]  shift_q;
    logic [N-1:0]  hold_q;
    logic [CW-1:0] bitcnt_q;
    logic          dacdat_q;
    logic          underrun_q;

    // Two flops of synchronisation, the third only delays for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[1:0], bclk};
            lr_sync_q   <= {lr_sync_q[1:0], daclrc};
        end
    end

    assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
    assign lr_fall   = lr_sync_q[2] & ~lr_sync_q[1];
    assign lr_rise   = ~lr_sync_q[2] & lr_sync_q[1];

    assign fifo_empty  = (fill_q == '0);
    assign ready       = (fill_q != (AW+1)'(DEPTH));
    assign push        = valid & ready;
    assign frame_start = lr_fall & (state_q != LEFT);
    assign pop         = frame_start & ~fifo_empty;
    assign glitch      = (lr_fall & (state_q == LEFT)) | (lr_rise & (state_q != LEFT));

    always_comb begin
        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + (AW+1)'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            fill_q <= fill_d;
        end
    end

    // An LR edge that coincides with a BCLK fall only loads, giving the one-BCLK I2S delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            bitcnt_q   <= '0;
            dacdat_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (frame_start) begin
                shift_q    <= pop ? mem_q[rd_ptr_q] : '0;
                hold_q     <= pop ? mem_q[rd_ptr_q] : '0;
                underrun_q <= fifo_empty;
                bitcnt_q   <= CW'(N);
                state_q    <= LEFT;
            end else if (glitch) begin
                state_q  <= IDLE;
                dacdat_q <= 1'b0;
            end else if (lr_rise) begin
                shift_q  <= hold_q;
                bitcnt_q <= CW'(N);
                state_q  <= RIGHT;
            end else if (bclk_fall && state_q != IDLE) begin
                if (bitcnt_q != '0) begin
                    dacdat_q <= shift_q[N-1];
                    shift_q  <= {shift_q[N-2:0], 1'b0};
                    bitcnt_q <= bitcnt_q - CW'(1);
                end else begin
                    dacdat_q <= 1'b0;
                end
            end
        end
    end

    assign dacdat   = dacdat_q;
    assign underrun = underrun_q;
    assign fill     = fill_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomised bench for i2s_dac_tx: the bench plays codec master, and a queue-based
// model predicts the serial bit stream, FIFO occupancy and underrun pulses.
module tb_i2s_dac_tx;
    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int HALF  = 163;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           sample_data;
    logic                   valid;
    logic                   ready;
    logic                   bclk;
    logic                   daclrc;
    logic                   dacdat;
    logic                   underrun;
    logic [$clog2(DEPTH):0] fill;

    int           n_checks = 0;
    int           n_errors = 0;
    int           und_cnt  = 0;
    logic [N-1:0] mq[$];
    logic         exp_out;

    i2s_dac_tx #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sample_data(sample_data), .valid(valid),
        .ready(ready), .bclk(bclk), .daclrc(daclrc), .dacdat(dacdat),
        .underrun(underrun), .fill(fill)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (underrun === 1'b1) und_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [N-1:0] v);
        @(negedge clk);
        sample_data = v;
        valid       = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(v);
    endtask

    // One BCLK period; line state is checked just before the rising edge.
    task automatic bclk_tick(input string tag);
        bclk = 1'b0;
        #HALF;
        check_eq({tag, "_dacdat"}, dacdat, exp_out);
        check_eq({tag, "_fill"}, fill, mq.size());
        check_eq({tag, "_ready"}, ready, mq.size() != DEPTH);
        bclk = 1'b1;
        #HALF;
    endtask

    // One stereo frame of f BCLKs per channel; optionally push a sample push_off clks in.
    task automatic run_frame(input int f, input int push_off, input logic [N-1:0] push_val);
        logic [N-1:0] cur;
        logic         und;
        int           u0;
        und = (mq.size() == 0);
        cur = und ? '0 : mq.pop_front();
        u0  = und_cnt;
        fork
            begin
                for (int ch = 0; ch < 2; ch++) begin
                    for (int k = 0; k < f; k++) begin
                        if (k == 0) daclrc = (ch == 1);
                        if (k >= 1) exp_out = (k <= N) ? cur[N-k] : 1'b0;
                        bclk_tick("frame");
                    end
                end
            end
            begin
                if (push_off >= 0) begin
                    repeat (push_off) @(posedge clk);
                    push(push_val);
                end
            end
        join
        check_eq("underrun", und_cnt - u0, {31'd0, und});
    endtask

    initial begin
        logic [N-1:0] cur;
        reset = 1'b1; valid = 1'b0; sample_data = '0;
        bclk = 1'b1; daclrc = 1'b1; exp_out = 1'b0;
        #50;
        check_eq("rst_dacdat", dacdat, 0);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_fill", fill, 0);
        check_eq("rst_underrun", underrun, 0);
        #47 reset = 1'b0;
        #60;

        // Known pattern, then empty frames, then a lone MSB.
        push(16'hA5C3);
        check_eq("fill_one", fill, 1);
        run_frame(32, -1, '0);
        run_frame(32, -1, '0);
        run_frame(32, -1, '0);
        push(16'h8000);
        run_frame(32, -1, '0);

        // Fill the FIFO, then hold off a ninth sample.
        for (int i = 0; i < DEPTH; i++) push(N'($urandom));
        check_eq("full_fill", fill, mq.size());
        @(negedge clk);
        sample_data = 16'hDEAD;
        valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("held_fill", fill, mq.size());
            check_eq("held_ready", ready, mq.size() != DEPTH);
        end
        valid = 1'b0;
        run_frame(32, -1, '0);
        while (mq.size() > 0) run_frame($urandom_range(8, 32), -1, '0);

        // Push landing near the lr_fall detect cycle with one sample queued.
        push(N'($urandom));
        for (int off = 0; off < 5; off++) run_frame(32, off, 16'h1234 + N'(off));
        run_frame(32, -1, '0);

        // Short frame truncates, the following full frame realigns.
        push(N'($urandom));
        push(N'($urandom));
        run_frame(8, -1, '0);
        run_frame(32, -1, '0);

        // Reset mid-left-channel after five bits; bit 11 set so the line is high.
        push(N'($urandom) | 16'h0800);
        push(N'($urandom));
        push(N'($urandom));
        cur = mq.pop_front();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) daclrc = 1'b0;
            if (k >= 1) exp_out = cur[N-k];
            bclk_tick("pre_rst");
        end
        #37 reset = 1'b1;
        #1;
        check_eq("midrst_dacdat", dacdat, 0);
        check_eq("midrst_fill", fill, 0);
        check_eq("midrst_ready", ready, 1);
        check_eq("midrst_underrun", underrun, 0);
        mq.delete();
        exp_out = 1'b0;
        #100 reset = 1'b0;
        #100;
        daclrc = 1'b1;
        repeat (8) bclk_tick("post_rst");
        run_frame(32, -1, '0);
        push(N'($urandom));
        run_frame($urandom_range(16, 32), -1, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
